// File: rtl/stream_minmax.sv
// stream_minmax
//
// Streaming min/max/count reducer. It accepts unsigned samples one per cycle
// on an input valid/ready stream and tracks the running minimum, maximum and
// sample count of a frame. A frame ends on a sample flagged in_last. The
// frame result is then held on an output valid/ready stream until the
// consumer takes it.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer holds data stable while valid is high. in_ready depends only
// on the FSM state, never combinationally on out_ready or in_valid.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_data/in_last valid this cycle
//   in_ready   block can accept a sample this cycle
//   in_data    sample value (unsigned, WIDTH bits)
//   in_last    sample is the final sample of the current frame
//   out_valid  frame result valid; held until accepted
//   out_ready  consumer accepts the result this cycle
//   out_min    smallest sample of the frame
//   out_max    largest sample of the frame
//   out_count  number of samples in the frame, saturating at 2^CNT_W-1
module stream_minmax #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_min,
   output logic [WIDTH-1:0] out_max,
   output logic [CNT_W-1:0] out_count
);

   // EMPTY: no sample of the current frame yet
   // ACC  : at least one sample accumulated
   // DONE : result held, waiting for the consumer
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ACC   = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] min_q;
   logic [WIDTH-1:0] max_q;
   logic [CNT_W-1:0] count_q;

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // Next-state and handshake outputs
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         EMPTY: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = in_last ? DONE : ACC;
            end
         end
         ACC: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = EMPTY;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Result registers. They are left untouched when the result is consumed;
   // the next frame's first sample reloads them.
   always_ff @(posedge clk) begin
      if (rst) begin
         min_q   <= '0;
         max_q   <= '0;
         count_q <= '0;
      end else if (in_fire) begin
         if (state == EMPTY) begin
            min_q   <= in_data;
            max_q   <= in_data;
            count_q <= CNT_W'(1);
         end else begin
            // Strict compares: on a tie the held value stays.
            if (in_data < min_q) begin
               min_q <= in_data;
            end
            if (in_data > max_q) begin
               max_q <= in_data;
            end
            // Count sticks at all-ones; min/max keep tracking.
            if (count_q != '1) begin
               count_q <= count_q + CNT_W'(1);
            end
         end
      end
   end

   // out_fire only drives the FSM; kept as a named net for checker binding.
   logic unused_out_fire;
   assign unused_out_fire = out_fire;

   assign out_min   = min_q;
   assign out_max   = max_q;
   assign out_count = count_q;

endmodule

// File: tb/tb_stream_minmax.sv
// Testbench for stream_minmax: directed steps plus randomized frames,
// checked against a frame-level reference model (min/max/count computed
// from the whole list of samples in a frame).
module tb_stream_minmax;

   localparam int WIDTH = 8;
   localparam int CNT_W = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_min;
   logic [WIDTH-1:0] out_max;
   logic [CNT_W-1:0] out_count;

   stream_minmax #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_min   (out_min),
      .out_max   (out_max),
      .out_count (out_count)
   );

   // scoreboard
   int vectors = 0;
   int miscompares = 0;
   logic [WIDTH-1:0] fq[$];                          // samples of the frame being sent
   logic [2*WIDTH+CNT_W-1:0] exp_q[$];               // expected {min,max,count}

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // one full clock: active edge, then back to the falling edge where the
   // bench samples outputs and changes inputs
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // reference model: reduce the whole frame with plain arithmetic
   task automatic push_model();
      int mn, mx, n;
      mn = 1 << WIDTH;
      mx = -1;
      foreach (fq[i]) begin
         if (int'(fq[i]) < mn) mn = int'(fq[i]);
         if (int'(fq[i]) > mx) mx = int'(fq[i]);
      end
      n = (fq.size() > CNT_MAX) ? CNT_MAX : fq.size();
      exp_q.push_back({WIDTH'(mn), WIDTH'(mx), CNT_W'(n)});
   endtask

   task automatic offer(input logic [WIDTH-1:0] d, input logic l);
      in_valid  = 1'b1;
      in_data   = d;
      in_last   = l;
      out_ready = 1'($urandom);     // irrelevant while accumulating
      check("in_ready_acc", 32'(in_ready), 32'd1);
      check("out_valid_acc", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      in_last  = 1'($urandom);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b0;
         in_data  = WIDTH'($urandom);
         in_last  = 1'($urandom);
         tick();
      end
   endtask

   // Called right after the edge that accepted the last sample.
   task automatic finish_frame(input int bp);
      logic [2*WIDTH+CNT_W-1:0] e;
      e = exp_q.pop_front();
      check("out_valid_done", 32'(out_valid), 32'd1);
      check("out_min", 32'(out_min), 32'(e[2*WIDTH+CNT_W-1 -: WIDTH]));
      check("out_max", 32'(out_max), 32'(e[WIDTH+CNT_W-1 -: WIDTH]));
      check("out_count", 32'(out_count), 32'(e[CNT_W-1:0]));
      for (int k = 0; k < bp; k++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;          // must not be absorbed
         in_data   = WIDTH'($urandom);
         in_last   = 1'($urandom);
         check("in_ready_done", 32'(in_ready), 32'd0);
         tick();
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_min", 32'(out_min), 32'(e[2*WIDTH+CNT_W-1 -: WIDTH]));
         check("bp_max", 32'(out_max), 32'(e[WIDTH+CNT_W-1 -: WIDTH]));
         check("bp_count", 32'(out_count), 32'(e[CNT_W-1:0]));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("in_ready_done", 32'(in_ready), 32'd0);
      tick();
      out_ready = 1'b0;
      check("out_valid_after", 32'(out_valid), 32'd0);
      check("in_ready_after", 32'(in_ready), 32'd1);
   endtask

   task automatic run_frame(input int gap_max, input int bp);
      push_model();
      foreach (fq[i]) begin
         idle($urandom_range(0, gap_max));
         offer(fq[i], i == fq.size() - 1);
      end
      finish_frame(bp);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_min", 32'(out_min), 32'd0);
      check("rst_max", 32'(out_max), 32'd0);
      check("rst_count", 32'(out_count), 32'd0);

      // reset mid-frame discards the partial frame
      offer(8'd5, 1'b0);
      offer(8'd9, 1'b0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_min", 32'(out_min), 32'd0);
      check("midrst_max", 32'(out_max), 32'd0);
      check("midrst_count", 32'(out_count), 32'd0);
      fq = '{8'd7};
      run_frame(0, 0);

      // reset with a pending result: no out_valid afterwards
      offer(8'd1, 1'b1);
      check("pend_out_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("pendrst_out_valid", 32'(out_valid), 32'd0);
      check("pendrst_count", 32'(out_count), 32'd0);
      tick();
      check("pendrst_out_valid2", 32'(out_valid), 32'd0);

      // basic frame
      fq = '{8'd5, 8'd200, 8'd3, 8'd17};
      run_frame(0, 0);

      // extremes and ties
      fq = '{8'd0, 8'd255, 8'd255, 8'd0};
      run_frame(0, 0);
      fq = '{8'd128, 8'd128};
      run_frame(0, 0);

      // backpressure
      fq = '{8'd10, 8'd20};
      run_frame(0, 5);

      // input gaps with in_data toggling while idle
      fq = '{8'd50, 8'd40, 8'd60};
      push_model();
      offer(8'd50, 1'b0);
      idle(3);
      offer(8'd40, 1'b0);
      idle(1);
      offer(8'd60, 1'b1);
      finish_frame(0);

      // count saturation
      fq.delete();
      for (int i = 0; i < 300; i++) fq.push_back(WIDTH'(i % 256));
      run_frame(0, 0);

      // randomized frames
      for (int f = 0; f < 40; f++) begin
         fq.delete();
         for (int i = 0; i < int'($urandom_range(1, 12)); i++)
            fq.push_back(WIDTH'($urandom));
         run_frame($urandom_range(0, 2), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
